// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared game constants and round state encoding
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_HIT       = 2'd2,
    ST_GAME_OVER = 2'd3
  } game_state_t;

  localparam int NUM_LIVES_DEFAULT     = 3;
  localparam int CLK_FREQ_HZ           = 25_000_000;
  // One second of blanking at the pixel clock.
  localparam int INVULN_CYCLES_DEFAULT = CLK_FREQ_HZ;

endpackage

// File: rtl/invuln_timer.sv
// rtl/invuln_timer.sv - loadable down-counter with zero flag for post-hit blanking
module invuln_timer #(
  parameter int WIDTH = 3
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Val,
  output logic             o_Zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count <= '0;
    end else if (i_Load) begin
      count <= i_Load_Val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign o_Zero = (count == '0);

endmodule

// File: rtl/life_manager.sv
// rtl/life_manager.sv - life budget and round FSM; LIFE_BONUS_EN enables level-up extra lives
module life_manager
  import frogger_pkg::*;
#(
  parameter int NUM_LIVES     = NUM_LIVES_DEFAULT,
  parameter int INVULN_CYCLES = INVULN_CYCLES_DEFAULT
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Game_Start,
  input  logic                 i_Collided,
  input  logic                 i_Level_Up,
  output logic [2:0]           o_Lives,
  output logic [NUM_LIVES-1:0] o_Life_LEDs,
  output logic                 o_Respawn,
  output logic                 o_Game_Active,
  output logic                 o_Invuln,
  output logic                 o_Game_Over
);

  localparam int         TIMER_W    = $clog2(INVULN_CYCLES);
  localparam logic [2:0] FULL_LIVES = 3'(NUM_LIVES);

  game_state_t          state, next_state;
  logic                 start_q;
  logic                 start_edge;
  logic                 timer_load, timer_zero;
  logic                 want_respawn;
  logic [2:0]           bonus_lives, next_lives;
  logic [NUM_LIVES-1:0] next_leds;

  assign start_edge = i_Game_Start & ~start_q;

  invuln_timer #(.WIDTH(TIMER_W)) u_invuln_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (timer_load),
    .i_Load_Val (TIMER_W'(INVULN_CYCLES - 1)),
    .o_Zero     (timer_zero)
  );

`ifdef LIFE_BONUS_EN
  // Bonus is applied before any same-cycle hit is evaluated.
  always_comb begin
    bonus_lives = o_Lives;
    if (i_Level_Up && (state == ST_PLAYING || state == ST_HIT) && o_Lives < FULL_LIVES)
      bonus_lives = o_Lives + 3'd1;
  end
`else
  logic unused_level_up;
  assign unused_level_up = i_Level_Up;
  assign bonus_lives     = o_Lives;
`endif

  always_comb begin
    next_state   = state;
    next_lives   = bonus_lives;
    want_respawn = 1'b0;
    timer_load   = 1'b0;
    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          next_state   = ST_PLAYING;
          next_lives   = FULL_LIVES;
          want_respawn = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (i_Collided) begin
          if (bonus_lives <= 3'd1) begin
            next_lives = 3'd0;
            next_state = ST_GAME_OVER;
          end else begin
            next_lives   = bonus_lives - 3'd1;
            next_state   = ST_HIT;
            timer_load   = 1'b1;
            want_respawn = 1'b1;
          end
        end
      end
      ST_HIT: begin
        if (timer_zero) next_state = ST_PLAYING;
      end
      default: next_state = ST_IDLE;
    endcase
    for (int k = 0; k < NUM_LIVES; k++) next_leds[k] = (next_lives > k[2:0]);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= ST_IDLE;
      start_q       <= 1'b0;
      o_Lives       <= FULL_LIVES;
      o_Life_LEDs   <= '1;
      o_Respawn     <= 1'b0;
      o_Game_Active <= 1'b0;
      o_Invuln      <= 1'b0;
      o_Game_Over   <= 1'b0;
    end else begin
      state         <= next_state;
      start_q       <= i_Game_Start;
      o_Lives       <= next_lives;
      o_Life_LEDs   <= next_leds;
      // Guard keeps the frog controller from seeing a stretched request.
      o_Respawn     <= want_respawn & ~o_Respawn;
      o_Game_Active <= (next_state == ST_PLAYING) || (next_state == ST_HIT);
      o_Invuln      <= (next_state == ST_HIT);
      o_Game_Over   <= (next_state == ST_GAME_OVER);
    end
  end

endmodule

// File: tb/tb_life_manager.sv
// tb/tb_life_manager.sv - scoreboard bench for life_manager with 3 lives and 8-cycle blanking
module tb_life_manager;

  localparam int NL = 3;
  localparam int IC = 8;

  logic          i_Clk;
  logic          i_Rst;
  logic          i_Game_Start;
  logic          i_Collided;
  logic          i_Level_Up;
  logic [2:0]    o_Lives;
  logic [NL-1:0] o_Life_LEDs;
  logic          o_Respawn;
  logic          o_Game_Active;
  logic          o_Invuln;
  logic          o_Game_Over;

  life_manager #(.NUM_LIVES(NL), .INVULN_CYCLES(IC)) dut (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Game_Start  (i_Game_Start),
    .i_Collided    (i_Collided),
    .i_Level_Up    (i_Level_Up),
    .o_Lives       (o_Lives),
    .o_Life_LEDs   (o_Life_LEDs),
    .o_Respawn     (o_Respawn),
    .o_Game_Active (o_Game_Active),
    .o_Invuln      (o_Invuln),
    .o_Game_Over   (o_Game_Over)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       prev_resp = 1'b0;

  // Expected vector: {lives, leds, respawn, active, invuln, game_over}
  task automatic cyc(input logic rst, input logic st, input logic col, input logic lvl,
                     input logic [2:0] lives, input logic [2:0] leds,
                     input logic resp, input logic act, input logic inv, input logic ovr,
                     input string tag);
    @(negedge i_Clk);
    i_Rst        = rst;
    i_Game_Start = st;
    i_Collided   = col;
    i_Level_Up   = lvl;
    exp_q.push_back({lives, leds, resp, act, inv, ovr});
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    logic [9:0] exp_v, act_v;
    string      tag;
    forever begin
      @(posedge i_Clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act_v = {o_Lives, o_Life_LEDs, o_Respawn, o_Game_Active, o_Invuln, o_Game_Over};
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL %s: got lives/leds/resp/act/inv/over=%b required %b", tag, act_v, exp_v);
        end
        n_cmp++;
        if (o_Respawn && prev_resp) begin
          n_bad++;
          $display("FAIL respawn_twice at %s: got 2 consecutive pulses required 1", tag);
        end
      end
      prev_resp = o_Respawn;
    end
  end

  initial begin
    i_Rst = 1'b1; i_Game_Start = 1'b0; i_Collided = 1'b0; i_Level_Up = 1'b0;

    cyc(1,0,0,0, 3,3'b111, 0,0,0,0, "reset");
    cyc(1,0,0,0, 3,3'b111, 0,0,0,0, "reset2");
    cyc(0,0,1,1, 3,3'b111, 0,0,0,0, "idle_collide");
    cyc(0,1,0,0, 3,3'b111, 1,1,0,0, "start");
    cyc(0,1,0,0, 3,3'b111, 0,1,0,0, "start_held");
    cyc(0,1,0,0, 3,3'b111, 0,1,0,0, "start_held");
    cyc(0,0,0,0, 3,3'b111, 0,1,0,0, "playing");

    // collision held for 20 cycles: two hits then game over
    cyc(0,0,1,0, 2,3'b011, 1,1,1,0, "hit1");
    for (int i = 0; i < IC-1; i++) cyc(0,0,1,0, 2,3'b011, 0,1,1,0, "hit1_invuln");
    cyc(0,0,1,0, 2,3'b011, 0,1,0,0, "hit1_end");
    cyc(0,0,1,0, 1,3'b001, 1,1,1,0, "hit2");
    for (int i = 0; i < IC-1; i++) cyc(0,0,1,0, 1,3'b001, 0,1,1,0, "hit2_invuln");
    cyc(0,0,1,0, 1,3'b001, 0,1,0,0, "hit2_end");
    cyc(0,0,1,0, 0,3'b000, 0,0,0,1, "game_over");
    cyc(0,0,1,0, 0,3'b000, 0,0,0,1, "go_hold");

    cyc(0,0,1,1, 0,3'b000, 0,0,0,1, "go_collide");
    cyc(0,1,0,0, 3,3'b111, 1,1,0,0, "restart");
    cyc(0,1,0,0, 3,3'b111, 0,1,0,0, "restart_held");
    cyc(0,1,0,0, 3,3'b111, 0,1,0,0, "restart_held");
    cyc(0,0,0,0, 3,3'b111, 0,1,0,0, "restart_release");

    // collision pulses during HIT must not shorten or extend blanking
    cyc(0,0,1,0, 2,3'b011, 1,1,1,0, "hit_p");
    for (int i = 0; i < IC-1; i++) cyc(0,0,(i % 2 == 0),0, 2,3'b011, 0,1,1,0, "hit_pulses");
    cyc(0,0,0,0, 2,3'b011, 0,1,0,0, "hit_p_end");

    // reset while blanking with the timer at 5
    cyc(0,0,1,0, 1,3'b001, 1,1,1,0, "hit3");
    cyc(0,0,0,0, 1,3'b001, 0,1,1,0, "hit3_t6");
    cyc(0,0,0,0, 1,3'b001, 0,1,1,0, "hit3_t5");
    cyc(1,0,1,0, 3,3'b111, 0,0,0,0, "rst_in_hit");
    cyc(0,0,0,0, 3,3'b111, 0,0,0,0, "post_rst_idle");

`ifdef LIFE_BONUS_EN
    cyc(0,1,0,0, 3,3'b111, 1,1,0,0, "b_start");
    cyc(0,0,0,0, 3,3'b111, 0,1,0,0, "b_play");
    cyc(0,0,0,1, 3,3'b111, 0,1,0,0, "bonus_sat");
    cyc(0,0,1,0, 2,3'b011, 1,1,1,0, "b_hit1");
    for (int i = 0; i < IC-1; i++) cyc(0,0,0,0, 2,3'b011, 0,1,1,0, "b_hit1_invuln");
    cyc(0,0,0,0, 2,3'b011, 0,1,0,0, "b_hit1_end");
    cyc(0,0,1,0, 1,3'b001, 1,1,1,0, "b_hit2");
    for (int i = 0; i < IC-1; i++) cyc(0,0,0,0, 1,3'b001, 0,1,1,0, "b_hit2_invuln");
    cyc(0,0,0,0, 1,3'b001, 0,1,0,0, "b_hit2_end");
    cyc(0,0,1,1, 1,3'b001, 1,1,1,0, "bonus_hit");
    cyc(0,0,0,0, 1,3'b001, 0,1,1,0, "bonus_hit_invuln");
`endif

    @(negedge i_Clk);
    i_Collided = 1'b0; i_Game_Start = 1'b0; i_Level_Up = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge i_Clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/life_manager.md
Name: life_manager

Overview:
- Downstream consumer of the game top's registered collision flag; owns the player-life budget and the round-level state machine (idle, playing, hit/invulnerable, game over).
- Drives the life LEDs (thermometer), a one-cycle respawn request to the frog controller, and game-active/game-over flags for the video and score paths.
- Replaces the bare lives counter; adds invulnerability blanking after a hit and restart handling.

Parameters:
- NUM_LIVES, 3, lives loaded at game start; LED vector width; range 1..7.
- INVULN_CYCLES, 25000000, clock cycles of collision blanking after a non-fatal hit (1 s at 25 MHz); must be ≥2.

Ports:
- i_Clk, input, 1, system clock (25 MHz pixel clock).
- i_Rst, input, 1, synchronous active-high reset.
- i_Game_Start, input, 1, start button level (already debounced); a rising edge is the event.
- i_Collided, input, 1, registered frog/car overlap flag; level-sensitive.
- i_Level_Up, input, 1, one-cycle pulse when the score increments; used only with the optional feature.
- o_Lives, output, 3, current life count.
- o_Life_LEDs, output, NUM_LIVES, thermometer code; bit k = (o_Lives > k).
- o_Respawn, output, 1, one-cycle pulse telling the frog controller to return the frog to the start tile.
- o_Game_Active, output, 1, high in PLAYING and HIT.
- o_Invuln, output, 1, high in HIT.
- o_Game_Over, output, 1, high in GAME_OVER.

Behaviour:
- All outputs are registered and respond 1 cycle after the sampling edge.
- Reset (synchronous, any state, mid-operation included):
  - state=IDLE, o_Lives=NUM_LIVES, o_Life_LEDs all 1.
  - o_Respawn=0, o_Game_Active=0, o_Invuln=0, o_Game_Over=0.
  - Timer=0; start-edge register=0.
- Start edge = i_Game_Start & ~start_q; start_q is registered every cycle in every state.
- IDLE:
  - Collisions are ignored.
  - On a start edge: go to PLAYING, reload o_Lives=NUM_LIVES, pulse o_Respawn.
- PLAYING, on i_Collided=1:
  - If o_Lives==1: o_Lives becomes 0, go to GAME_OVER, no respawn pulse.
  - Otherwise: o_Lives is decremented, go to HIT, timer loads INVULN_CYCLES-1, pulse o_Respawn.
- HIT:
  - i_Collided is ignored.
  - Timer decrements each cycle; when timer==0, go to PLAYING on the next edge.
  - Total HIT duration is exactly INVULN_CYCLES cycles.
  - If i_Collided is still high on the first PLAYING cycle, it counts as a new hit.
- GAME_OVER:
  - o_Lives holds 0; collisions are ignored.
  - A start edge behaves exactly as the IDLE start (reload lives, respawn pulse, PLAYING).
- A start edge while in PLAYING or HIT is ignored.
- o_Respawn is never high for 2 consecutive cycles.
- Arithmetic: the lives counter never underflows below 0 and never exceeds NUM_LIVES. The timer width is $clog2(INVULN_CYCLES).

Optional Feature:
- Macro: LIFE_BONUS_EN.
- Defined:
  - An i_Level_Up pulse in PLAYING or HIT adds 1 life, saturating at NUM_LIVES.
  - If an i_Level_Up pulse and a collision land in the same PLAYING cycle, the bonus applies first, then the hit. With 1 life, the result is 1 life and the state goes to HIT, not GAME_OVER.
  - Pulses in IDLE and GAME_OVER are ignored.
- Undefined: i_Level_Up is unused (port retained, tie-off allowed); lives only decrement.

Decomposition:
- Shared package frogger_pkg holds:
  - the state enum (IDLE, PLAYING, HIT, GAME_OVER);
  - the NUM_LIVES default constant;
  - the clock frequency constant used to derive INVULN_CYCLES.
- One natural sub-module: invuln_timer, a loadable down-counter with a zero flag (ports: clock, reset, load, load value, zero).

Test Plan (sim with INVULN_CYCLES=8, NUM_LIVES=3):
- Reset, then a start edge → PLAYING one cycle later; o_Lives=3, o_Life_LEDs=111, o_Respawn high exactly 1 cycle.
- Hold i_Collided high for 20 cycles in PLAYING:
  - first hit gives o_Lives=2, LEDs=011, o_Invuln high 8 cycles;
  - second hit on the first PLAYING cycle gives o_Lives=1;
  - third hit gives o_Lives=0 and GAME_OVER;
  - exactly 2 respawn pulses total.
- Collision pulses during HIT → o_Lives unchanged, HIT still lasts 8 cycles.
- In GAME_OVER:
  - collision has no effect;
  - start held high (level) gives a single restart, o_Lives=3, o_Game_Over=0.
- Assert i_Rst while in HIT with timer at 5 → IDLE next cycle, o_Lives=3, o_Invuln=0, no respawn pulse.
- LIFE_BONUS_EN defined:
  - at 1 life, simultaneous i_Level_Up and i_Collided gives o_Lives=1, HIT;
  - at 3 lives, i_Level_Up gives o_Lives stays 3.
